tdm_mac: RTL



---
 rtl/tdm_mac_pkg.sv | 22 ++
 rtl/tdm_mac_mult.sv | 34 +++
 rtl/tdm_mac.sv | 135 +++++++++++++
 3 files changed

// File: rtl/tdm_mac_pkg.sv
// Shared types and width helpers for the time-multiplexed MAC engine.
// Optional build macro: TDM_MAC_SIGNED_EN (two's-complement operands).
package tdm_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-precision product width for one operand pair
    function automatic int unsigned prod_width(input int unsigned data_w);
        return 2 * data_w;
    endfunction

    // Accumulator width: product plus growth for n_taps additions, never wraps
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned n_taps);
        return prod_width(data_w) + $clog2(n_taps);
    endfunction

endpackage

// File: rtl/tdm_mac_mult.sv
// Combinational DATA_W x DATA_W multiplier, product extended to ACC_W.
// TDM_MAC_SIGNED_EN selects two's-complement operands and sign extension.
module tdm_mac_mult
    import tdm_mac_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 2 * DATA_W + 1
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_k,
    output logic [ACC_W-1:0]  o_prod
);

    localparam int unsigned PROD_W = prod_width(DATA_W);
    localparam int unsigned EXT_W  = ACC_W - PROD_W;

    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_k_ext;
    logic [PROD_W-1:0] w_prod;

`ifdef TDM_MAC_SIGNED_EN
    // Low PROD_W bits of the extended product are the exact signed product
    assign w_a_ext = {{DATA_W{i_a[DATA_W-1]}}, i_a};
    assign w_k_ext = {{DATA_W{i_k[DATA_W-1]}}, i_k};
    assign w_prod  = w_a_ext * w_k_ext;
    assign o_prod  = {{EXT_W{w_prod[PROD_W-1]}}, w_prod};
`else
    assign w_a_ext = {{DATA_W{1'b0}}, i_a};
    assign w_k_ext = {{DATA_W{1'b0}}, i_k};
    assign w_prod  = w_a_ext * w_k_ext;
    assign o_prod  = {{EXT_W{1'b0}}, w_prod};
`endif

endmodule

// File: rtl/tdm_mac.sv
// Sequential dot-product engine: one shared multiplier walks N_TAPS operand
// pairs per vector set. Build macro TDM_MAC_SIGNED_EN enables signed mode.
module tdm_mac
    import tdm_mac_pkg::*;
#(
    parameter int unsigned  DATA_W = 8,
    parameter int unsigned  N_TAPS = 9,
    localparam int unsigned ACC_W  = acc_width(DATA_W, N_TAPS),
    localparam int unsigned TAP_W  = $clog2(N_TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_TAPS*DATA_W-1:0] a_flat,
    input  logic [N_TAPS*DATA_W-1:0] k_flat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         result,
    output logic [TAP_W-1:0]         tap_idx
);

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(N_TAPS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_load;
    logic              w_acc_en;
    logic              w_last;

    logic [DATA_W-1:0] r_a [N_TAPS];
    logic [DATA_W-1:0] r_k [N_TAPS];
    logic [TAP_W-1:0]  r_tap_idx;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_result;
    logic              r_in_ready;
    logic              r_out_valid;

    logic [DATA_W-1:0] w_a_sel;
    logic [DATA_W-1:0] w_k_sel;
    logic [ACC_W-1:0]  w_prod;
    logic [ACC_W-1:0]  w_acc_sum;

    assign w_a_sel   = r_a[r_tap_idx];
    assign w_k_sel   = r_k[r_tap_idx];
    assign w_acc_sum = r_acc + w_prod;

    tdm_mac_mult #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mult (
        .i_a    (w_a_sel),
        .i_k    (w_k_sel),
        .o_prod (w_prod)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_acc_en    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = MAC;
                end
            end
            MAC: begin
                w_acc_en = 1'b1;
                if (r_tap_idx == TAP_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, accumulation and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_TAPS); i++) begin
                r_a[i] <= '0;
                r_k[i] <= '0;
            end
            r_tap_idx   <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            if (w_load) begin
                for (int i = 0; i < int'(N_TAPS); i++) begin
                    r_a[i] <= a_flat[i*DATA_W +: DATA_W];
                    r_k[i] <= k_flat[i*DATA_W +: DATA_W];
                end
                r_acc     <= '0;
                r_tap_idx <= '0;
            end else if (w_acc_en) begin
                r_acc     <= w_acc_sum;
                r_tap_idx <= w_last ? '0 : r_tap_idx + TAP_W'(1);
            end
            // Result is frozen from the final accumulate until the next completion
            if (w_last) begin
                r_result <= w_acc_sum;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign tap_idx   = r_tap_idx;

endmodule
